dm_lsu: RTL and testbench
=========================

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of data-memory word count (1024 words = 4 KB).
REQ-002 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Addr_M  in  32  byte address from M-stage ALU result.
REQ-005 SHALL have port WD_M  in  32  store data (rt), unshifted.
REQ-006 SHALL have port BE_M  in  4  byte enables from the M-stage byte-enable generator.
REQ-007 SHALL have port MemWrite_M  in  1  store request.
REQ-008 SHALL have port MemRead_M  in  1  load request.
REQ-009 SHALL have port LdType_M  in  3  000 lw, 001 lbu, 010 lb, 011 lhu, 100 lh; others treated as lw.
REQ-010 SHALL have port En  in  1  pipeline advance; 0 = stall.
REQ-011 SHALL have port Flush_M  in  1  kill current M op.
REQ-012 SHALL have port RD_W  out  32  extended load data for writeback.
REQ-013 SHALL have port Valid_W  out  1  RD_W holds a completed load.
REQ-014 SHALL have ports AdEL_W, AdES_W  out  1 each  load/store address-error flags.

Function
REQ-015 SHALL hold 2^DEPTH_LOG2 x 32-bit words, index Addr_M[DEPTH_LOG2+1:2]; higher address bits ignored.
REQ-016 SHALL lane-align store data: BE 1111 -> WD_M; BE 0011/1100 -> {2{WD_M[15:0]}}; single-bit BE -> {4{WD_M[7:0]}}.
REQ-017 SHALL write lane i (bits 8i+7:8i) at the rising edge only when MemWrite_M=1, En=1, Flush_M=0, rst_n=1, BE_M[i]=1, no AdES; BE 0000 writes nothing.
REQ-018 SHALL, at a rising edge with En=1, load W registers: word read (old contents), Addr_M[1:0], LdType_M, Valid_W <= MemRead_M & ~MemWrite_M & ~Flush_M.
REQ-019 SHALL give load latency exactly 1 cycle: load in cycle N, RD_W/Valid_W valid in cycle N+1.
REQ-020 SHALL produce RD_W combinationally from W registers: lbu/lb select byte Addr[1:0], zero/sign extend; lhu/lh select half Addr[1], zero/sign extend; lw passes word.
REQ-021 SHALL, with En=0, hold all W registers and perform no memory write.
REQ-022 SHALL, on MemRead_M and MemWrite_M both 1, perform the write only and set Valid_W=0.
REQ-023 SHALL return the new data for a load in cycle N+1 to the address stored in cycle N.
REQ-024 SHALL drive RD_W=0 whenever Valid_W=0.

Reset
REQ-025 SHALL, while rst_n=0, force Valid_W, AdEL_W, AdES_W and all W registers to 0 (RD_W=0) immediately, independent of clk.
REQ-026 SHALL suppress memory writes while rst_n=0; memory contents SHALL NOT be reset.
REQ-027 SHALL resume normal operation at the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro DM_ALIGN_CHECK_EN defined, register AdEL_W=1 for lw with Addr_M[1:0]!=00 or lh/lhu with Addr_M[0]=1, and AdES_W=1 for BE 1111 with Addr_M[1:0]!=00 or halfword BE with Addr_M[0]=1; flagged ops SHALL write nothing and set Valid_W=0.
REQ-029 SHALL, without DM_ALIGN_CHECK_EN, tie AdEL_W/AdES_W to 0 and execute misaligned accesses using the low address bits as given (lw ignores Addr[1:0]).

Verification
REQ-030 SHALL cover: store 0x11223344, BE 1111 @0x10; load lw @0x10 -> RD_W=0x11223344, Valid_W=1 next cycle.
REQ-031 SHALL cover: store WD 0x000000AB, BE 1000 @0x13; lw @0x10 -> 0xAB223344; lb @0x13 -> 0xFFFFFFAB; lbu -> 0x000000AB.
REQ-032 SHALL cover: store WD 0x00008001, BE 1100 @0x12; lh @0x12 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-033 SHALL cover: lw @0x10 then En=0 for 3 cycles with a store presented -> RD_W held, memory unchanged.
REQ-034 SHALL cover: rst_n pulsed low mid-cycle while Valid_W=1 -> Valid_W=0 and RD_W=0 immediately; store data from before reset still readable after.
REQ-035 SHALL cover (DM_ALIGN_CHECK_EN): lw @0x11 -> AdEL_W=1, Valid_W=0; store BE 1111 @0x12 -> AdES_W=1, memory unchanged.

Source files
------------

// File: rtl/dm_lsu.sv
// Data-memory load/store unit: word-wide RAM with byte-lane stores and a 1-cycle registered load path.
// Optional macro DM_ALIGN_CHECK_EN enables address-alignment checking (AdEL_W / AdES_W).
module dm_lsu #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Addr_M,
    input  logic [31:0] WD_M,
    input  logic [3:0]  BE_M,
    input  logic        MemWrite_M,
    input  logic        MemRead_M,
    input  logic [2:0]  LdType_M,
    input  logic        En,
    input  logic        Flush_M,
    output logic [31:0] RD_W,
    output logic        Valid_W,
    output logic        AdEL_W,
    output logic        AdES_W
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LBU = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LH  = 3'b100;

    logic [31:0] mem [0:WORDS-1];

    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            addr_lo;
    logic                  unused_addr_hi;

    assign idx            = Addr_M[DEPTH_LOG2+1:2];
    assign addr_lo        = Addr_M[1:0];
    assign unused_addr_hi = ^Addr_M[31:DEPTH_LOG2+2];

    logic load_req;
    logic store_req;
    logic adel_d;
    logic ades_d;
    logic valid_d;
    logic write_en;

    assign load_req  = MemRead_M & ~MemWrite_M & ~Flush_M;
    assign store_req = MemWrite_M & ~Flush_M;

`ifdef DM_ALIGN_CHECK_EN
    logic ld_misaligned;
    logic st_misaligned;

    always_comb begin
        ld_misaligned = 1'b0;
        case (LdType_M)
            LD_LBU, LD_LB: ld_misaligned = 1'b0;
            LD_LHU, LD_LH: ld_misaligned = addr_lo[0];
            default:       ld_misaligned = (addr_lo != 2'b00);
        endcase
    end

    always_comb begin
        st_misaligned = 1'b0;
        case (BE_M)
            4'b1111:         st_misaligned = (addr_lo != 2'b00);
            4'b0011, 4'b1100: st_misaligned = addr_lo[0];
            default:         st_misaligned = 1'b0;
        endcase
    end

    assign adel_d = load_req & ld_misaligned;
    assign ades_d = store_req & st_misaligned;
`else
    assign adel_d = 1'b0;
    assign ades_d = 1'b0;
`endif

    assign valid_d  = load_req & ~adel_d;
    assign write_en = store_req & En & rst_n & ~ades_d;

    // Replicate store data so the enabled lanes see the right bytes.
    logic [31:0] wd_lane;

    always_comb begin
        wd_lane = WD_M;
        case (BE_M)
            4'b1111:                            wd_lane = WD_M;
            4'b0011, 4'b1100:                   wd_lane = {2{WD_M[15:0]}};
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wd_lane = {4{WD_M[7:0]}};
            default:                            wd_lane = WD_M;
        endcase
    end

    // NOTE: the RAM array has no reset branch; reset only gates the write enable so contents survive.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (BE_M[i]) begin
                    mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
                end
            end
        end
    end

    logic [31:0] word_q;
    logic [1:0]  lo_q;
    logic [2:0]  ld_type_q;
    logic        valid_q;
    logic        adel_q;
    logic        ades_q;

    // NOTE: non-blocking read of mem here captures the pre-write word when a store hits the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            lo_q      <= '0;
            ld_type_q <= '0;
            valid_q   <= 1'b0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
        end else if (En) begin
            word_q    <= mem[idx];
            lo_q      <= addr_lo;
            ld_type_q <= LdType_M;
            valid_q   <= valid_d;
            adel_q    <= adel_d;
            ades_q    <= ades_d;
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] rd_ext;

    always_comb begin
        sel_byte = word_q[8*lo_q +: 8];
        sel_half = lo_q[1] ? word_q[31:16] : word_q[15:0];
        rd_ext   = word_q;
        case (ld_type_q)
            LD_LBU:  rd_ext = {24'h0, sel_byte};
            LD_LB:   rd_ext = {{24{sel_byte[7]}}, sel_byte};
            LD_LHU:  rd_ext = {16'h0, sel_half};
            LD_LH:   rd_ext = {{16{sel_half[15]}}, sel_half};
            LD_LW:   rd_ext = word_q;
            default: rd_ext = word_q;
        endcase
    end

    assign RD_W    = valid_q ? rd_ext : 32'h0;
    assign Valid_W = valid_q;
    assign AdEL_W  = adel_q;
    assign AdES_W  = ades_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Self-checking bench for dm_lsu: directed scenarios plus random traffic against a byte-array reference model.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Addr_M;
    logic [31:0] WD_M;
    logic [3:0]  BE_M;
    logic        MemWrite_M;
    logic        MemRead_M;
    logic [2:0]  LdType_M;
    logic        En;
    logic        Flush_M;
    logic [31:0] RD_W;
    logic        Valid_W;
    logic        AdEL_W;
    logic        AdES_W;

    always #5 clk = ~clk;

    dm_lsu #(.DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Addr_M     (Addr_M),
        .WD_M       (WD_M),
        .BE_M       (BE_M),
        .MemWrite_M (MemWrite_M),
        .MemRead_M  (MemRead_M),
        .LdType_M   (LdType_M),
        .En         (En),
        .Flush_M    (Flush_M),
        .RD_W       (RD_W),
        .Valid_W    (Valid_W),
        .AdEL_W     (AdEL_W),
        .AdES_W     (AdES_W)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: a flat byte array, 4 KB.
    logic [7:0]  mbytes [0:4095];
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic        exp_adel;
    logic        exp_ades;

    function automatic int word_base(input logic [31:0] a);
        logic [9:0] w;
        w = a[11:2];
        return int'(w) * 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] ty);
        int          base;
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        base = word_base(a);
        off  = int'(a[1:0]);
        case (ty)
            3'd1, 3'd2: begin
                b = mbytes[base + off];
                return (ty == 3'd2 && b >= 8'd128) ? (32'hFFFFFF00 | 32'(b)) : 32'(b);
            end
            3'd3, 3'd4: begin
                off = (off >= 2) ? 2 : 0;
                h   = {mbytes[base + off + 1], mbytes[base + off]};
                return (ty == 3'd4 && h >= 16'h8000) ? (32'hFFFF0000 | 32'(h)) : 32'(h);
            end
            default: return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
        endcase
    endfunction

    // Byte that lane i receives for a given enable pattern.
    function automatic logic [7:0] lane_byte(input logic [3:0] be, input logic [31:0] wd, input int i);
        logic [31:0] sh;
        if (be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000)
            return wd[7:0];
        if (be == 4'b0011 || be == 4'b1100) begin
            sh = wd >> (8 * (i % 2));
            return sh[7:0];
        end
        sh = wd >> (8 * i);
        return sh[7:0];
    endfunction

    task automatic do_op(input string tag, input bit we, input bit re, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] ty,
                         input bit en = 1'b1, input bit fl = 1'b0);
        bit ld;
        bit st;
        bit adel;
        bit ades;
        int base;
        MemWrite_M = we;
        MemRead_M  = re;
        BE_M       = be;
        Addr_M     = addr;
        WD_M       = wd;
        LdType_M   = ty;
        En         = en;
        Flush_M    = fl;
        if (en) begin
            ld   = re && !we && !fl;
            st   = we && !fl;
            adel = 1'b0;
            ades = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
            if (ld) begin
                if (ty == 3'd3 || ty == 3'd4) adel = (addr % 2) != 0;
                else if (ty != 3'd1 && ty != 3'd2) adel = (addr % 4) != 0;
            end
            if (st) begin
                if (be == 4'hF) ades = (addr % 4) != 0;
                else if (be == 4'b0011 || be == 4'b1100) ades = (addr % 2) != 0;
            end
`endif
            exp_adel  = adel;
            exp_ades  = ades;
            exp_valid = ld && !adel;
            exp_rd    = exp_valid ? model_read(addr, ty) : 32'h0;
            if (st && !ades) begin
                base = word_base(addr);
                for (int i = 0; i < 4; i++)
                    if (be[i]) mbytes[base + i] = lane_byte(be, wd, i);
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".rd"},    RD_W,    exp_rd);
        check({tag, ".valid"}, Valid_W, 32'(exp_valid));
        check({tag, ".adel"},  AdEL_W,  32'(exp_adel));
        check({tag, ".ades"},  AdES_W,  32'(exp_ades));
    endtask

    task automatic idle_inputs();
        MemWrite_M = 1'b0;
        MemRead_M  = 1'b0;
        BE_M       = 4'h0;
        Addr_M     = 32'h0;
        WD_M       = 32'h0;
        LdType_M   = 3'd0;
        En         = 1'b1;
        Flush_M    = 1'b0;
    endtask

    initial begin
        logic [3:0]  be_tab [0:7];
        logic [31:0] r;
        logic [9:0]  widx;
        logic [3:0]  be;
        bit          we;
        bit          re;
        bit          en;
        bit          fl;

        be_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        rst_n = 1'b0;
        idle_inputs();
        exp_rd = 0; exp_valid = 0; exp_adel = 0; exp_ades = 0;

        #12;
        check("reset.rd",    RD_W,    32'h0);
        check("reset.valid", Valid_W, 32'h0);
        check("reset.adel",  AdEL_W,  32'h0);
        check("reset.ades",  AdES_W,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++)
            do_op("init", 1'b1, 1'b0, 4'hF, 32'(i) << 2, $urandom, 3'd0);

        do_op("st_word", 1'b1, 1'b0, 4'hF, 32'h10, 32'h11223344, 3'd0);
        do_op("lw_10",   1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("lw_10.const", RD_W, 32'h11223344);

        do_op("sb_13",  1'b1, 1'b0, 4'b1000, 32'h13, 32'h000000AB, 3'd0);
        do_op("lw_10b", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("lw_10b.const", RD_W, 32'hAB223344);
        do_op("lb_13",  1'b0, 1'b1, 4'h0, 32'h13, 32'h0, 3'd2);
        check("lb_13.const", RD_W, 32'hFFFFFFAB);
        do_op("lbu_13", 1'b0, 1'b1, 4'h0, 32'h13, 32'h0, 3'd1);
        check("lbu_13.const", RD_W, 32'h000000AB);

        do_op("sh_12",  1'b1, 1'b0, 4'b1100, 32'h12, 32'h00008001, 3'd0);
        do_op("lh_12",  1'b0, 1'b1, 4'h0, 32'h12, 32'h0, 3'd4);
        check("lh_12.const", RD_W, 32'hFFFF8001);
        do_op("lhu_12", 1'b0, 1'b1, 4'h0, 32'h12, 32'h0, 3'd3);
        check("lhu_12.const", RD_W, 32'h00008001);

        do_op("stall_lw", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            do_op("stall", 1'b1, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 3'd0, 1'b0);
            check("stall.held", RD_W, 32'h80013344);
        end
        do_op("post_stall", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("post_stall.const", RD_W, 32'h80013344);

        do_op("flush_st", 1'b1, 1'b0, 4'hF, 32'h10, 32'h0BADF00D, 3'd0, 1'b1, 1'b1);
        do_op("flush_ld", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0, 1'b1, 1'b1);
        do_op("both",     1'b1, 1'b1, 4'b0001, 32'h20, 32'h0000005A, 3'd0);
        do_op("post_flush", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("post_flush.const", RD_W, 32'h80013344);

        do_op("pre_rst", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", Valid_W, 32'h0);
        check("async_rst.rd",    RD_W,    32'h0);
        exp_rd = 0; exp_valid = 0; exp_adel = 0; exp_ades = 0;
        MemWrite_M = 1'b1; BE_M = 4'hF; Addr_M = 32'h10; WD_M = 32'h0;
        @(posedge clk);
        #1;
        check("in_rst.valid", Valid_W, 32'h0);
        rst_n = 1'b1;
        idle_inputs();
        do_op("after_rst", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("after_rst.const", RD_W, 32'h80013344);

`ifdef DM_ALIGN_CHECK_EN
        do_op("mis_lw", 1'b0, 1'b1, 4'h0, 32'h11, 32'h0, 3'd0);
        check("mis_lw.adel", AdEL_W, 32'h1);
        do_op("mis_sw", 1'b1, 1'b0, 4'hF, 32'h12, 32'h55555555, 3'd0);
        check("mis_sw.ades", AdES_W, 32'h1);
`else
        do_op("mis_lw", 1'b0, 1'b1, 4'h0, 32'h11, 32'h0, 3'd0);
        check("mis_lw.const", RD_W, 32'h80013344);
        do_op("mis_sw", 1'b1, 1'b0, 4'hF, 32'h52, 32'h55555555, 3'd0);
`endif
        do_op("mis_chk", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 3'd0);
        check("mis_chk.const", RD_W, 32'h80013344);

        for (int n = 0; n < 400; n++) begin
            r    = $urandom;
            widx = 10'($urandom_range(0, 63));
            be   = ($urandom_range(0, 8) == 8) ? 4'($urandom) : be_tab[$urandom_range(0, 7)];
            we   = ($urandom_range(0, 2) == 0);
            re   = ($urandom_range(0, 1) == 0);
            en   = ($urandom_range(0, 5) != 0);
            fl   = ($urandom_range(0, 7) == 0);
            do_op("rand", we, re, be, {r[31:12], widx, r[1:0]}, $urandom,
                  3'($urandom_range(0, 7)), en, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
